// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and width helpers for the async FIFO write-side arbiter.
//   state_t     : arbiter FSM encoding (IDLE=0, GRANT=1)
//   id_width()  : source-ID width for a given requester count
//   word_width(): FIFO word width, source ID plus payload
package fifo_arb_pkg;

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   function automatic int id_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int word_width(input int n, input int dw);
      return id_width(n) + dw;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   i_req    : request vector, bit i = requester i
//   i_rr_ptr : last served requester; search starts at i_rr_ptr+1 mod NUM_REQ
//   o_idx    : winning requester index (valid when o_any)
//   o_any    : at least one request present
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_rr_ptr,
   output logic [ID_W-1:0]    o_idx,
   output logic               o_any
);

   logic [NUM_REQ-1:0] w_rot;
   int                 w_start;
   int                 w_off;

   // Rotate so the highest-priority requester sits at bit 0, take the lowest set bit,
   // then map the offset back; mod keeps non-power-of-2 counts inside 0..NUM_REQ-1.
   always_comb begin
      w_start = (int'(i_rr_ptr) + 1) % NUM_REQ;
      w_rot   = '0;
      for (int k = 0; k < NUM_REQ; k++) w_rot[k] = i_req[(w_start + k) % NUM_REQ];
      w_off = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) if (w_rot[k]) w_off = k;
      o_idx = ID_W'((w_start + w_off) % NUM_REQ);
      o_any = |i_req;
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: packet-atomic round-robin scheduler for the async FIFO write port.
//   wclk, wrst_n  : write clock, asynchronous active-low reset
//   i_arb_en      : allow new grants; an active packet always completes
//   i_req_valid   : per-requester word valid
//   i_req_last    : per-requester last word of packet
//   i_req_data    : packed payloads, requester i at [i*DATA_W +: DATA_W]
//   o_req_ready   : per-requester word accept
//   i_full        : FIFO full flag
//   o_wr_en       : FIFO write strobe
//   o_wdata       : {grant_id, payload of granted requester}
//   o_grant_id    : currently granted requester
//   o_busy        : high while a packet grant is held
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int ID_W    = id_width(NUM_REQ)
) (
   input  logic                      wclk,
   input  logic                      wrst_n,
   input  logic                      i_arb_en,
   input  logic [NUM_REQ-1:0]        i_req_valid,
   input  logic [NUM_REQ-1:0]        i_req_last,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
   output logic [NUM_REQ-1:0]        o_req_ready,
   input  logic                      i_full,
   output logic                      o_wr_en,
   output logic [ID_W+DATA_W-1:0]    o_wdata,
   output logic [ID_W-1:0]           o_grant_id,
   output logic                      o_busy
);

   state_t              r_state;
   logic [ID_W-1:0]     r_grant_id;
   logic [ID_W-1:0]     r_rr_ptr;
   logic [ID_W-1:0]     w_win;
   logic                w_any;
   logic                w_grant;
   logic [DATA_W-1:0]   w_sel_data;

   rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
      .i_req    (i_req_valid),
      .i_rr_ptr (r_rr_ptr),
      .o_idx    (w_win),
      .o_any    (w_any)
   );

   assign w_grant     = (r_state == GRANT);
   assign w_sel_data  = i_req_data[int'(r_grant_id)*DATA_W +: DATA_W];
   assign o_wr_en     = w_grant & i_req_valid[r_grant_id] & ~i_full;
   assign o_req_ready = (w_grant & ~i_full) ? (NUM_REQ'(1) << r_grant_id) : '0;
   assign o_wdata     = {r_grant_id, w_sel_data};
   assign o_grant_id  = r_grant_id;
   assign o_busy      = w_grant;

   // Grant is released only by an accepted last beat; the cycle after is always IDLE,
   // so a competing request is arbitrated one cycle later.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_state    <= IDLE;
         r_grant_id <= '0;
         r_rr_ptr   <= ID_W'(NUM_REQ - 1);
      end else begin
         case (r_state)
            IDLE: if (i_arb_en && w_any) begin
               r_grant_id <= w_win;
               r_state    <= GRANT;
            end
            GRANT: if (o_wr_en && i_req_last[r_grant_id]) begin
               r_rr_ptr <= r_grant_id;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
